// File: rtl/fixed_multiplier.sv
// Sequential shift-add multiplier for 32-bit sign-magnitude fixed point (Q7.24 magnitude).
// State | meaning: IDLE | waiting for operands; BUSY | one multiplier bit per edge; DONE | result valid for one cycle.
module fixed_multiplier #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             accept_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             accept_out,
    output logic             ready_out,
    output logic [WIDTH-1:0] prod
);
    localparam int MAG_W = WIDTH - 1;
    localparam int ACC_W = 2 * MAG_W;
    localparam int CNT_W = $clog2(MAG_W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state;
    logic               r_sign;
    logic [MAG_W-1:0]   r_ma;
    logic [MAG_W-1:0]   r_mb;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [ACC_W-1:0]   w_addend;
    logic               w_ovf;
    logic [MAG_W-1:0]   w_mag;
    logic               w_last;

    assign w_addend = r_mb[r_cnt] ? ({{MAG_W{1'b0}}, r_ma} << r_cnt) : '0;
    // Anything above the integer field means the product does not fit: clamp.
    assign w_ovf    = |r_acc[ACC_W-1:FRAC+MAG_W];
    assign w_mag    = w_ovf ? {MAG_W{1'b1}} : r_acc[FRAC+MAG_W-1:FRAC];
    assign w_last   = (r_cnt == CNT_W'(MAG_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            accept_out <= 1'b0;
            ready_out  <= 1'b1;
            prod       <= '0;
        end else if (enable) begin
            case (r_state)
                IDLE, DONE: begin
                    accept_out <= 1'b0;
                    if (accept_in) begin
                        r_sign    <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_ma      <= A[MAG_W-1:0];
                        r_mb      <= B[MAG_W-1:0];
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        ready_out <= 1'b0;
                        r_state   <= BUSY;
                    end else begin
                        ready_out <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                BUSY: begin
                    // Counter reaching MAG_W means all bits consumed; this edge only publishes.
                    if (w_last) begin
                        prod       <= {r_sign, w_mag};
                        accept_out <= 1'b1;
                        ready_out  <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_acc <= r_acc + w_addend;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    accept_out <= 1'b0;
                    ready_out  <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_multiplier.sv
// Directed-vector bench for fixed_multiplier: latency, sign/fraction, saturation,
// stalls, back-to-back issue and asynchronous reset abort.
module tb_fixed_multiplier;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        accept_in;
    logic [31:0] A;
    logic [31:0] B;
    logic        accept_out;
    logic        ready_out;
    logic [31:0] prod;

    int vectors    = 0;
    int miscompares = 0;

    fixed_multiplier dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .accept_in  (accept_in),
        .A          (A),
        .B          (B),
        .accept_out (accept_out),
        .ready_out  (ready_out),
        .prod       (prod)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits (bounded) for the result pulse; lat = -1 on timeout.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] p, output int rdy_hi);
        A = a;
        B = b;
        accept_in = 1'b1;
        tick();
        accept_in = 1'b0;
        lat = -1;
        p = 32'hxxxxxxxx;
        rdy_hi = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (accept_out) begin
                lat = n;
                p = prod;
                break;
            end
            if (ready_out) rdy_hi++;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (ready_out !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
        vectors++;
        if (accept_out !== 1'b0) begin miscompares++; $display("FAIL reset_accept: got %b expected 0", accept_out); end
        vectors++;
        if (prod !== 32'h0) begin miscompares++; $display("FAIL reset_prod: got %h expected 00000000", prod); end
        reset_n = 1'b1;
        tick();
        tick();
        vectors++;
        if (ready_out !== 1'b1 || accept_out !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got ready=%b accept=%b expected ready=1 accept=0", ready_out, accept_out);
        end
    endtask

    task automatic test_basic();
        int lat, rdy_hi;
        logic [31:0] p;
        do_op(32'h01800000, 32'h02000000, lat, p, rdy_hi);
        vectors++;
        if (lat != 32) begin miscompares++; $display("FAIL basic_latency: got %0d expected 32", lat); end
        vectors++;
        if (p !== 32'h03000000) begin miscompares++; $display("FAIL basic_prod: got %h expected 03000000", p); end
        vectors++;
        if (rdy_hi != 0) begin miscompares++; $display("FAIL basic_ready_low: got %0d ready-high cycles expected 0", rdy_hi); end
        tick();
        vectors++;
        if (accept_out !== 1'b0 || ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_single_pulse: got accept=%b ready=%b expected accept=0 ready=1", accept_out, ready_out);
        end
    endtask

    task automatic test_sign_fraction();
        logic [31:0] va [6] = '{32'h81800000, 32'h80800000, 32'h40000000, 32'h80000001, 32'h00000003, 32'h00000000};
        logic [31:0] vb [6] = '{32'h02000000, 32'h80800000, 32'h04000000, 32'h00800000, 32'h00800000, 32'h85000000};
        logic [31:0] ve [6] = '{32'h83000000, 32'h00400000, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'h80000000};
        int lat, rdy_hi;
        logic [31:0] p;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], lat, p, rdy_hi);
            vectors++;
            if (p !== ve[i] || lat != 32) begin
                miscompares++;
                $display("FAIL vector_%0d: got prod=%h lat=%0d expected prod=%h lat=32", i, p, lat, ve[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int lat, rdy_hi;
        logic [31:0] p;
        A = 32'h01800000;
        B = 32'h02000000;
        accept_in = 1'b1;
        tick();
        accept_in = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            enable = (n >= 6 && n <= 15) ? 1'b0 : 1'b1;
            tick();
            if (accept_out) begin
                lat = n;
                break;
            end
        end
        enable = 1'b1;
        vectors++;
        if (lat != 42) begin miscompares++; $display("FAIL stall_busy_latency: got %0d expected 42", lat); end
        vectors++;
        if (prod !== 32'h03000000) begin miscompares++; $display("FAIL stall_busy_prod: got %h expected 03000000", prod); end
        tick();

        do_op(32'h02000000, 32'h00800000, lat, p, rdy_hi);
        enable = 1'b0;
        repeat (6) tick();
        vectors++;
        if (accept_out !== 1'b1 || prod !== 32'h01000000) begin
            miscompares++;
            $display("FAIL stall_done_hold: got accept=%b prod=%h expected accept=1 prod=01000000", accept_out, prod);
        end
        enable = 1'b1;
        tick();
        vectors++;
        if (accept_out !== 1'b0) begin miscompares++; $display("FAIL stall_done_release: got %b expected 0", accept_out); end
    endtask

    task automatic test_back_to_back();
        int lat, rdy_hi, unstable, extra;
        logic [31:0] p;
        do_op(32'h01800000, 32'h82000000, lat, p, rdy_hi);
        vectors++;
        if (p !== 32'h83000000) begin miscompares++; $display("FAIL b2b_first: got %h expected 83000000", p); end
        A = 32'h00400000;
        B = 32'h83000000;
        accept_in = 1'b1;
        tick();
        accept_in = 1'b0;
        vectors++;
        if (accept_out !== 1'b0 || ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_capture: got accept=%b ready=%b expected accept=0 ready=0", accept_out, ready_out);
        end
        lat = -1;
        unstable = 0;
        for (int n = 1; n <= 100; n++) begin
            if (n == 5 || n == 20) begin
                A = 32'h7FFFFFFF;
                B = 32'h7FFFFFFF;
                accept_in = 1'b1;
            end else begin
                accept_in = 1'b0;
            end
            tick();
            if (accept_out) begin
                lat = n;
                p = prod;
                break;
            end
            if (prod !== 32'h83000000) unstable++;
        end
        accept_in = 1'b0;
        vectors++;
        if (unstable != 0) begin miscompares++; $display("FAIL b2b_prod_stable: got %0d changed cycles expected 0", unstable); end
        vectors++;
        if (lat != 32 || p !== 32'h80C00000) begin
            miscompares++;
            $display("FAIL b2b_second: got prod=%h lat=%0d expected prod=80C00000 lat=32", p, lat);
        end
        extra = 0;
        repeat (40) begin
            tick();
            if (accept_out) extra++;
        end
        vectors++;
        if (extra != 0) begin miscompares++; $display("FAIL b2b_no_extra: got %0d pulses expected 0", extra); end
    endtask

    task automatic test_reset_midop();
        int lat, rdy_hi, extra;
        logic [31:0] p;
        A = 32'h01800000;
        B = 32'h02000000;
        accept_in = 1'b1;
        tick();
        accept_in = 1'b0;
        repeat (15) tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (ready_out !== 1'b1 || accept_out !== 1'b0 || prod !== 32'h0) begin
            miscompares++;
            $display("FAIL midop_reset: got ready=%b accept=%b prod=%h expected 1 0 00000000", ready_out, accept_out, prod);
        end
        tick();
        tick();
        reset_n = 1'b1;
        extra = 0;
        repeat (40) begin
            tick();
            if (accept_out) extra++;
        end
        vectors++;
        if (extra != 0) begin miscompares++; $display("FAIL midop_no_result: got %0d pulses expected 0", extra); end
        do_op(32'h03000000, 32'h00C00000, lat, p, rdy_hi);
        vectors++;
        if (lat != 32 || p !== 32'h02400000) begin
            miscompares++;
            $display("FAIL midop_recover: got prod=%h lat=%0d expected prod=02400000 lat=32", p, lat);
        end
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        accept_in = 1'b0;
        A         = '0;
        B         = '0;
        #12;
        test_reset();
        test_basic();
        test_sign_fraction();
        test_stall();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
